// File: rtl/prog_sequencer.sv
// Program-counter sequencer: walks an instruction ROM address through IDLE -> RUN -> DONE,
// applying decoder jump/branch/NOP-stall requests and keeping decoder mode, previous instruction and compare flags.
module prog_sequencer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        AckIn,
  input  logic        BranchEn,
  input  logic [8:0]  BranchTarget,
  input  logic        JumpEn,
  input  logic [8:0]  JumpAddr,
  input  logic [1:0]  NextState,
  input  logic [8:0]  PrevInstructionIn,
  input  logic [2:0]  CMPBitsIn,
  input  logic        CMPLoadEn,
  output logic [9:0]  ProgCtr,
  output logic [1:0]  CurrState,
  output logic [8:0]  PrevInstruction,
  output logic [2:0]  CMPBits,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] CycleCnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } seq_state_t;

  localparam logic [1:0] MODE_NOP = 2'b11;

  seq_state_t  state, state_next;
  logic        start_q;
  logic        stall;
  logic [9:0]  pc_next;
  logic [1:0]  cs_next;
  logic [8:0]  prev_next;
  logic [2:0]  cmp_next;
  logic [15:0] cnt_next;

  // start_q resets high so a Start already asserted at reset release cannot launch a run;
  // a run only begins on a low-to-high Start seen in IDLE.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state           <= S_IDLE;
      start_q         <= 1'b1;
      ProgCtr         <= '0;
      CurrState       <= '0;
      PrevInstruction <= '0;
      CMPBits         <= '0;
      CycleCnt        <= '0;
    end else begin
      state           <= state_next;
      start_q         <= Start;
      ProgCtr         <= pc_next;
      CurrState       <= cs_next;
      PrevInstruction <= prev_next;
      CMPBits         <= cmp_next;
      CycleCnt        <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = ProgCtr;
    cs_next    = CurrState;
    prev_next  = PrevInstruction;
    cmp_next   = CMPBits;
    cnt_next   = CycleCnt;
    stall      = (CurrState == MODE_NOP) && !JumpEn && !BranchEn;
    case (state)
      S_IDLE: begin
        pc_next = '0;
        cs_next = '0;
        if (Start && !start_q) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end
      end
      S_RUN: begin
        if (CycleCnt != 16'hFFFF) cnt_next = CycleCnt + 16'd1;
        if (AckIn) begin
          state_next = S_DONE;
        end else begin
          // Priority: jump > branch > NOP stall > increment; 10-bit adds wrap modulo 1024.
          if (JumpEn)        pc_next = {1'b0, JumpAddr};
          else if (BranchEn) pc_next = ProgCtr + {1'b0, BranchTarget};
          else if (!stall)   pc_next = ProgCtr + 10'd1;
          cs_next   = stall ? 2'b00 : NextState;
          prev_next = PrevInstructionIn;
          if (CMPLoadEn) cmp_next = CMPBitsIn;
        end
      end
      S_DONE: begin
        if (!Start) begin
          state_next = S_IDLE;
          pc_next    = '0;
          cs_next    = '0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign Busy = (state == S_RUN);
  assign Done = (state == S_DONE);

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed scenarios with fixed expected values, then a randomized
// run checked cycle by cycle against a behavioural model of the sequencer rules.
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, ack, br_en, j_en, cmp_en;
  logic [8:0]  br_tgt, j_addr, pin;
  logic [1:0]  nxt;
  logic [2:0]  cin;
  logic [9:0]  pc;
  logic [1:0]  cs;
  logic [8:0]  prev;
  logic [2:0]  cmp;
  logic        busy, done;
  logic [15:0] cnt;

  int n_total = 0;
  int n_bad   = 0;

  // behavioural model: mode 0 idle, 1 run, 2 done
  int          m_mode;
  bit          m_start_low_seen;
  int          m_pc, m_cs, m_prev, m_cmp, m_cnt;

  always #5 clk = ~clk;

  prog_sequencer dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .AckIn(ack),
    .BranchEn(br_en), .BranchTarget(br_tgt), .JumpEn(j_en), .JumpAddr(j_addr),
    .NextState(nxt), .PrevInstructionIn(pin), .CMPBitsIn(cin), .CMPLoadEn(cmp_en),
    .ProgCtr(pc), .CurrState(cs), .PrevInstruction(prev), .CMPBits(cmp),
    .Busy(busy), .Done(done), .CycleCnt(cnt)
  );

  task automatic model_reset();
    m_mode = 0; m_start_low_seen = 0;
    m_pc = 0; m_cs = 0; m_prev = 0; m_cmp = 0; m_cnt = 0;
  endtask

  // One clock of the sequencer rules, applied to the inputs present at the edge.
  task automatic model_step();
    bit go;
    go = (m_mode == 0) && start && m_start_low_seen;
    if (m_mode == 0) begin
      m_pc = 0; m_cs = 0;
      if (go) begin m_mode = 1; m_cnt = 0; end
    end else if (m_mode == 1) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (ack) m_mode = 2;
      else begin
        if (j_en)                  begin m_pc = j_addr; m_cs = nxt; end
        else if (br_en)            begin m_pc = (m_pc + br_tgt) % 1024; m_cs = nxt; end
        else if (m_cs == 3)        m_cs = 0;
        else                       begin m_pc = (m_pc + 1) % 1024; m_cs = nxt; end
        m_prev = pin;
        if (cmp_en) m_cmp = cin;
      end
    end else if (!start) begin
      m_mode = 0; m_pc = 0; m_cs = 0;
    end
    if (!start) m_start_low_seen = 1;
    else if (go) m_start_low_seen = 0;
  endtask

  task automatic clear_ctrl();
    ack = 0; br_en = 0; j_en = 0; cmp_en = 0;
    br_tgt = 0; j_addr = 0; nxt = 0; pin = 0; cin = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; clear_ctrl(); model_reset();
    #22;
    n_total++; if (pc !== 10'd0 || cs !== 2'd0 || prev !== 9'd0 || cmp !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_state: got pc=%0d cs=%0d prev=%0d cmp=%0d busy=%0b done=%0b cnt=%0d, want all 0", pc, cs, prev, cmp, busy, done, cnt);
    end
    @(negedge clk); rst_n = 1;
    tick();
    n_total++; if (busy !== 1'b0 || pc !== 10'd0) begin
      n_bad++; $display("FAIL idle_after_reset: got busy=%0b pc=%0d, want busy=0 pc=0", busy, pc);
    end
  endtask

  task automatic test_count();
    start = 1; tick(); start = 0;
    n_total++; if (busy !== 1'b1 || pc !== 10'd0 || cnt !== 16'd0) begin
      n_bad++; $display("FAIL run_entry: got busy=%0b pc=%0d cnt=%0d, want 1 0 0", busy, pc, cnt);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_total++; if (pc !== 10'(i) || busy !== 1'b1) begin
        n_bad++; $display("FAIL count_pc: got pc=%0d busy=%0b, want pc=%0d busy=1", pc, busy, i);
      end
    end
    n_total++; if (cnt !== 16'd5) begin
      n_bad++; $display("FAIL cycle_cnt: got %0d, want 5", cnt);
    end
  endtask

  task automatic test_branch_jump();
    tick(); tick();
    n_total++; if (pc !== 10'd7) begin n_bad++; $display("FAIL pre_branch_pc: got %0d, want 7", pc); end
    br_en = 1; br_tgt = 9'd2; tick();
    n_total++; if (pc !== 10'd9) begin n_bad++; $display("FAIL branch: got %0d, want 9", pc); end
    j_en = 1; j_addr = 9'h1F0; tick(); clear_ctrl();
    n_total++; if (pc !== 10'h1F0) begin n_bad++; $display("FAIL jump_over_branch: got %0h, want 1f0", pc); end
  endtask

  task automatic test_nop();
    j_en = 1; j_addr = 9'd4; tick(); clear_ctrl();
    nxt = 2'b11; tick();
    n_total++; if (pc !== 10'd5 || cs !== 2'b11) begin
      n_bad++; $display("FAIL nop_load: got pc=%0d cs=%0d, want pc=5 cs=3", pc, cs);
    end
    nxt = 2'b10; tick();
    n_total++; if (pc !== 10'd5 || cs !== 2'b00) begin
      n_bad++; $display("FAIL nop_stall: got pc=%0d cs=%0d, want pc=5 cs=0", pc, cs);
    end
    nxt = 2'b00; pin = 9'h155; tick();
    n_total++; if (pc !== 10'd6 || prev !== 9'h155) begin
      n_bad++; $display("FAIL after_nop: got pc=%0d prev=%0h, want pc=6 prev=155", pc, prev);
    end
    clear_ctrl();
  endtask

  task automatic test_wrap();
    j_en = 1; j_addr = 9'd511; tick(); clear_ctrl();
    br_en = 1; br_tgt = 9'd511; tick(); clear_ctrl();
    tick();
    n_total++; if (pc !== 10'd1023) begin n_bad++; $display("FAIL pc_1023: got %0d, want 1023", pc); end
    tick();
    n_total++; if (pc !== 10'd0) begin n_bad++; $display("FAIL inc_wrap: got %0d, want 0", pc); end
    j_en = 1; j_addr = 9'd511; tick(); clear_ctrl();
    br_en = 1; br_tgt = 9'd511; tick(); clear_ctrl();
    n_total++; if (pc !== 10'd1022) begin n_bad++; $display("FAIL pc_1022: got %0d, want 1022", pc); end
    br_en = 1; br_tgt = 9'd3; tick(); clear_ctrl();
    n_total++; if (pc !== 10'd1) begin n_bad++; $display("FAIL branch_wrap: got %0d, want 1", pc); end
  endtask

  task automatic test_ack_done();
    logic [2:0] cmp_before;
    j_en = 1; j_addr = 9'd12; tick(); clear_ctrl();
    start = 1; ack = 1; tick(); ack = 0;
    n_total++; if (done !== 1'b1 || busy !== 1'b0 || pc !== 10'd12) begin
      n_bad++; $display("FAIL ack_done: got done=%0b busy=%0b pc=%0d, want 1 0 12", done, busy, pc);
    end
    cmp_before = cmp;
    j_en = 1; j_addr = 9'd5; cmp_en = 1; cin = ~cmp_before; tick(); tick(); clear_ctrl();
    n_total++; if (done !== 1'b1 || pc !== 10'd12 || cmp !== cmp_before) begin
      n_bad++; $display("FAIL done_hold: got done=%0b pc=%0d cmp=%0d, want 1 12 %0d", done, pc, cmp, cmp_before);
    end
    start = 0; tick();
    n_total++; if (done !== 1'b0 || busy !== 1'b0 || pc !== 10'd0) begin
      n_bad++; $display("FAIL done_exit: got done=%0b busy=%0b pc=%0d, want 0 0 0", done, busy, pc);
    end
  endtask

  task automatic test_reset_midrun();
    start = 1; tick();
    cmp_en = 1; cin = 3'b101; tick(); clear_ctrl();
    n_total++; if (cmp !== 3'b101 || busy !== 1'b1) begin
      n_bad++; $display("FAIL cmp_load: got cmp=%0b busy=%0b, want 101 1", cmp, busy);
    end
    #3 rst_n = 0; model_reset();
    #1;
    n_total++; if (pc !== 10'd0 || cs !== 2'd0 || prev !== 9'd0 || cmp !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || cnt !== 16'd0) begin
      n_bad++; $display("FAIL async_reset: got pc=%0d cs=%0d prev=%0d cmp=%0d busy=%0b done=%0b cnt=%0d, want all 0", pc, cs, prev, cmp, busy, done, cnt);
    end
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL no_restart_high: got busy=%0b, want 0", busy); end
    end
    start = 0; tick();
    start = 1; tick();
    n_total++; if (busy !== 1'b1 || pc !== 10'd0) begin
      n_bad++; $display("FAIL restart_toggle: got busy=%0b pc=%0d, want 1 0", busy, pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      start  = ($urandom_range(0, 3) != 0);
      ack    = ($urandom_range(0, 24) == 0);
      j_en   = ($urandom_range(0, 7) == 0);
      br_en  = ($urandom_range(0, 5) == 0);
      cmp_en = $urandom_range(0, 1);
      br_tgt = 9'($urandom_range(0, 511));
      j_addr = 9'($urandom_range(0, 511));
      nxt    = 2'($urandom_range(0, 3));
      pin    = 9'($urandom_range(0, 511));
      cin    = 3'($urandom_range(0, 7));
      tick();
      n_total++; if (pc !== 10'(m_pc) || cs !== 2'(m_cs)) begin
        n_bad++; $display("FAIL rand_pc_cs[%0d]: got pc=%0d cs=%0d, want pc=%0d cs=%0d", i, pc, cs, m_pc, m_cs);
      end
      n_total++; if (prev !== 9'(m_prev) || cmp !== 3'(m_cmp)) begin
        n_bad++; $display("FAIL rand_prev_cmp[%0d]: got prev=%0d cmp=%0d, want prev=%0d cmp=%0d", i, prev, cmp, m_prev, m_cmp);
      end
      n_total++; if (busy !== (m_mode == 1) || done !== (m_mode == 2) || cnt !== 16'(m_cnt)) begin
        n_bad++; $display("FAIL rand_status[%0d]: got busy=%0b done=%0b cnt=%0d, want mode=%0d cnt=%0d", i, busy, done, cnt, m_mode, m_cnt);
      end
    end
    clear_ctrl();
  endtask

  initial begin
    test_reset();
    test_count();
    test_branch_jump();
    test_nop();
    test_wrap();
    test_ack_done();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low. Ports, one per line:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  level request; starts a program run from IDLE
- AckIn  in  1  decoder "done w/ program" strobe
- BranchEn  in  1  decoder relative-branch enable
- BranchTarget  in  9  relative PC offset, unsigned
- JumpEn  in  1  absolute jump enable (issued in Target mode)
- JumpAddr  in  9  absolute jump address (target word)
- NextState  in  2  decoder mode for the next cycle
- PrevInstructionIn  in  9  instruction to retain for the next cycle
- CMPBitsIn  in  3  compare flags {zero, equal, gt}
- CMPLoadEn  in  1  compare flag load enable
- ProgCtr  out  10  instruction ROM address
- CurrState  out  2  registered decoder mode: 00 Regular, 01 Target, 10 Imm, 11 NOP
- PrevInstruction  out  9  registered previous instruction
- CMPBits  out  3  registered compare flags
- Busy  out  1  high in RUN
- Done  out  1  high in DONE
- CycleCnt  out  16  RUN-cycle count

Function
REQ-002 SHALL implement the sequencer FSM IDLE -> RUN -> DONE -> IDLE; this FSM is separate from CurrState.
REQ-003 IDLE: ProgCtr and CurrState SHALL hold 0; Start=1 SHALL move to RUN, clear CycleCnt to 0, and set ProgCtr=0.
REQ-004 RUN: each cycle SHALL update ProgCtr with strict priority AckIn > JumpEn > BranchEn > NOP-stall > increment.
REQ-005 AckIn=1 in RUN SHALL move to DONE with ProgCtr held, and CurrState, PrevInstruction and CMPBits frozen.
REQ-006 JumpEn: ProgCtr SHALL load {1'b0, JumpAddr}.
REQ-007 BranchEn: ProgCtr SHALL load ProgCtr + zero-extended BranchTarget, modulo 1024.
REQ-008 CurrState == 11 (NOP) with no jump or branch: ProgCtr SHALL hold for one cycle, and CurrState SHALL load 00 regardless of NextState.
REQ-009 Default action SHALL be ProgCtr + 1, modulo 1024 (1023 wraps to 0).
REQ-010 In RUN without AckIn: CurrState SHALL load NextState (except REQ-008) and PrevInstruction SHALL load PrevInstructionIn every cycle.
REQ-011 CMPBits SHALL load CMPBitsIn only when in RUN with CMPLoadEn=1; otherwise hold.
REQ-012 CycleCnt SHALL increment on every RUN cycle, including the Ack cycle, and saturate at 16'hFFFF.
REQ-013 Outputs are registered; Busy SHALL equal (FSM==RUN) and Done SHALL equal (FSM==DONE).
REQ-014 Input latency is one cycle: an input sampled at edge N SHALL be visible on outputs after edge N.
REQ-015 DONE SHALL hold Done=1 and all state until Start=0, then go to IDLE; Start=1 in DONE SHALL keep DONE.
REQ-016 Start SHALL be ignored in RUN; a new run requires Start low then high through IDLE.
REQ-017 JumpEn, BranchEn and CMPLoadEn SHALL be ignored outside RUN.

Reset
REQ-018 Reset=0 SHALL immediately force IDLE and set ProgCtr=0, CurrState=00, PrevInstruction=0, CMPBits=000, Busy=0, Done=0, CycleCnt=0.
REQ-019 Reset asserted mid-RUN SHALL abort the run; after release the block SHALL wait in IDLE for Start, even if Start is already high.
REQ-020 Release of reset SHALL be synchronous to Clk; the first active edge after release performs normal IDLE behaviour.

Verification
REQ-021 Start=1 for 1 cycle, no control inputs for 5 cycles -> ProgCtr 0,1,2,3,4,5; Busy=1; CycleCnt=5.
REQ-022 At ProgCtr=7, BranchEn=1 with BranchTarget=2 -> ProgCtr=9. Then JumpEn=1 with BranchEn=1 and JumpAddr=0x1F0 -> ProgCtr=0x1F0, branch ignored.
REQ-023 NextState=11 for one cycle at ProgCtr=4 -> CurrState=11, ProgCtr=5. Next cycle -> ProgCtr stays 5, CurrState=00. Then ProgCtr=6.
REQ-024 ProgCtr=1023, no control inputs -> ProgCtr=0. BranchTarget=3 at ProgCtr=1022 -> ProgCtr=1.
REQ-025 AckIn=1 at ProgCtr=12 with Start held high -> Done=1, ProgCtr=12 held. Start dropped -> IDLE, ProgCtr=0, Done=0.
REQ-026 Reset=0 between edges mid-RUN with CMPBits=101 -> all outputs 0 at once. Start held high through release -> stays IDLE until Start toggles low then high.
